mult_seq: RTL and testbench
===========================

# mult_seq

Sequential 4x4 unsigned shift-add multiplier controller and datapath. It sits beside the 4-bit load-enabled operand register `mreg` and drives that register's load strobe `c1`. While `c1` is high, `mreg` captures the multiplicand from the shared input bus `ia`. This block then consumes the register output `q` (seen here as `mq`) over four add/shift cycles and presents an 8-bit product with a one-cycle `done` pulse.

## Interface
- No parameters; widths are fixed (4-bit operands, 8-bit product).
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rstn`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `start`  in  1  request a multiply; sampled only in IDLE.
- `ia`  in  4  shared operand bus; carries the multiplicand during LDM and the multiplier during LDQ. The same bus drives `mreg.ia`.
- `mq`  in  4  multiplicand, taken from `mreg.q`.
- `c1`  out  1  load strobe to `mreg.c1`; high only in LDM.
- `busy`  out  1  high in LDM, LDQ and RUN.
- `done`  out  1  one-cycle pulse in DONE.
- `p`  out  8  product, `{A,Q}`.

## Operation
- **States:** IDLE, LDM, LDQ, RUN, DONE. Registered state; Moore outputs.
- **IDLE:**
  - `start`=1 -> LDM.
  - Otherwise stay in IDLE.
  - `p` holds the last product.
- **LDM:**
  - `c1`=1, so `mreg` captures `ia` at the end of this cycle.
  - Always -> LDQ.
- **LDQ:**
  - Q <= `ia`, A <= 0, cnt <= 0.
  - -> RUN.
  - `mq` is valid from this cycle onward. `c1`=0 keeps `mreg` stable.
- **RUN, one step per cycle:**
  - sum[4:0] = {1'b0,A} + (Q[0] ? mq : 4'd0).
  - A <= sum[4:1].
  - Q <= {sum[0], Q[3:1]}.
  - cnt <= cnt+1.
  - When cnt==3 at the edge (the 4th step), -> DONE.
- **DONE:**
  - `done`=1; `p` holds the final product.
  - -> IDLE unconditionally.
  - `start` is ignored in DONE.
- **Arithmetic:**
  - Unsigned operands.
  - 5-bit intermediate sum; the carry is shifted into A[3].
  - No overflow is possible: the maximum product is 15*15 = 225.
- **`start` handling:** ignored in every state except IDLE. It is level-sampled, so holding `start` high gives back-to-back operations with one IDLE cycle between them.
- **Product between operations:** `p` keeps its value from DONE until the next LDQ clears A and loads Q.
  - During LDQ and RUN, `p` shows intermediate partial values.
  - `p` is meaningful only while `done`=1 or in IDLE.
- **Reset:**
  - `rstn`=0 at an edge -> IDLE, A=0, Q=0, cnt=0.
  - Outputs after reset: `c1`=0, `busy`=0, `done`=0, `p`=0.
  - Reset mid-operation aborts it; no `done` pulse is produced.
  - `mreg` has no reset, so its contents are don't-care until the next LDM.

## Timing
- Cycle numbering: cycle 0 is the IDLE cycle in which `start`=1.
  - cycle 1: LDM, `c1`=1, `ia` = multiplicand.
  - cycle 2: LDQ, `ia` = multiplier.
  - cycles 3-6: RUN, with steps committed at the ends of cycles 3, 4, 5 and 6.
  - cycle 7: DONE, `done`=1, `p` final.
  - cycle 8: IDLE.
- Latency from `start` to `done` is 7 cycles. Throughput is one product per 8 cycles.
- `c1` is high for exactly one cycle per operation.
- `busy` is high in cycles 1-6 and low in cycles 0, 7 and 8.
- `ia` is don't-care outside LDM and LDQ.
- `mq` must not change in cycles 2-6. This is guaranteed because `c1`=0.

## Test plan
- **Basic product:** after reset, `start`=1 in cycle 0, `ia`=3 in cycle 1, `ia`=5 in cycle 2 -> `c1` high only in cycle 1, `done` high only in cycle 7, `p`=0x0F.
- **Maximum operands:** multiplicand 15, multiplier 15 -> `p`=0xE1 in DONE. The carry into A[3] must be exercised.
- **Zero operands:**
  - multiplicand 0, multiplier 9 -> `p`=0x00.
  - multiplicand 9, multiplier 0 -> `p`=0x00.
- **Reset mid-operation:** `rstn`=0 during RUN cycle 4 -> next cycle IDLE, `busy`=0, `p`=0x00, and no `done` pulse in cycle 7.
- **Start held high continuously:**
  - operands (2,7) then (6,4) -> `done` in cycle 7 with `p`=0x0E, then `done` in cycle 15 with `p`=0x18.
  - Pulses of `start` during `busy` have no effect.
- **Post-reset state:** assert `rstn`=0 for one cycle -> `c1`=0, `busy`=0, `done`=0, `p`=0x00. The block stays idle while `start`=0.

Source files
------------

// File: rtl/mult_seq.sv
// -----------------------------------------------------------------------------
// mult_seq
//   Sequential 4x4 unsigned shift-add multiplier (controller + datapath).
//   Works beside an external load-enabled operand register (mreg): this block
//   strobes mreg's load enable (c1) for one cycle so mreg captures the
//   multiplicand from the shared bus, then loads the multiplier from the same
//   bus and performs four add/shift steps, producing an 8-bit product {A,Q}
//   with a one-cycle done pulse.
//
// Ports
//   clk    in   1  system clock, rising edge
//   rstn   in   1  synchronous active-low reset
//   start  in   1  multiply request, sampled only in IDLE
//   ia     in   4  shared operand bus (multiplicand in LDM, multiplier in LDQ)
//   mq     in   4  multiplicand from mreg.q
//   c1     out  1  mreg load strobe, high only in LDM
//   busy   out  1  high in LDM, LDQ and RUN
//   done   out  1  one-cycle pulse in DONE
//   p      out  8  product {A,Q}
// -----------------------------------------------------------------------------
module mult_seq (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start,
    input  logic [3:0] ia,
    input  logic [3:0] mq,
    output logic       c1,
    output logic       busy,
    output logic       done,
    output logic [7:0] p
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LDM  = 3'd1,
        LDQ  = 3'd2,
        RUN  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] acc;      // A: upper half of the product
    logic [3:0] mlt;      // Q: multiplier, shifted out as product low bits
    logic [1:0] cnt;
    logic [4:0] sum;

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and Moore outputs
    always_comb begin
        state_nxt = state;
        c1        = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LDM;
                end
            end
            LDM: begin
                c1        = 1'b1;
                busy      = 1'b1;
                state_nxt = LDQ;
            end
            LDQ: begin
                busy      = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == 2'd3) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // 5-bit partial sum; bit 4 is the carry that becomes the new A[3]
    always_comb begin
        sum = {1'b0, acc} + (mlt[0] ? {1'b0, mq} : 5'd0);
    end

    // Datapath: A, Q and step counter
    always_ff @(posedge clk) begin
        if (!rstn) begin
            acc <= 4'd0;
            mlt <= 4'd0;
            cnt <= 2'd0;
        end else begin
            case (state)
                LDQ: begin
                    acc <= 4'd0;
                    mlt <= ia;
                    cnt <= 2'd0;
                end
                RUN: begin
                    // Right shift of {carry, A, Q}: sum[0] drops into Q[3]
                    acc <= sum[4:1];
                    mlt <= {sum[0], mlt[3:1]};
                    cnt <= cnt + 2'd1;
                end
                default: begin
                    acc <= acc;
                    mlt <= mlt;
                    cnt <= cnt;
                end
            endcase
        end
    end

    assign p = {acc, mlt};

endmodule

// File: tb/tb_mult_seq.sv
module tb_mult_seq;

    logic       clk;
    logic       rstn;
    logic       start;
    logic [3:0] ia;
    logic [3:0] mq;
    logic       c1;
    logic       busy;
    logic       done;
    logic [7:0] p;

    // Behavioural stand-in for the external operand register (no reset)
    logic [3:0] mreg_q;

    int n_checks;
    int n_fail;

    mult_seq dut (
        .clk   (clk),
        .rstn  (rstn),
        .start (start),
        .ia    (ia),
        .mq    (mq),
        .c1    (c1),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (c1) mreg_q <= ia;
    end
    assign mq = mreg_q;

    // Advance to the next cycle; outputs are sampled 1 time unit after the edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        start = 1'b0;
        rstn  = 1'b0;
        cyc();
        rstn  = 1'b1;
        n_checks++;
        if ({c1, busy, done} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ctrl: {c1,busy,done}=%b required 000", {c1, busy, done});
        end
        n_checks++;
        if (p !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_p: p=%h required 00", p);
        end
        for (int k = 0; k < 4; k++) begin
            cyc();
            n_checks++;
            if ({c1, busy, done} !== 3'b000 || p !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_idle: cyc %0d {c1,busy,done}=%b p=%h required 000 / 00",
                         k, {c1, busy, done}, p);
            end
        end
    endtask

    // One full operation from an IDLE cycle; start is randomised while busy
    // and in DONE, where it must have no effect.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input string name);
        logic [7:0] exp_p;
        logic       e_c1, e_busy, e_done;
        exp_p = 8'(a) * 8'(b);
        start = 1'b1;
        ia    = 4'($urandom);
        for (int k = 1; k <= 8; k++) begin
            cyc();
            e_c1   = (k == 1);
            e_busy = (k >= 1 && k <= 6);
            e_done = (k == 7);
            n_checks++;
            if ({c1, busy, done} !== {e_c1, e_busy, e_done}) begin
                n_fail++;
                $display("FAIL %s_ctrl: cycle %0d {c1,busy,done}=%b required %b",
                         name, k, {c1, busy, done}, {e_c1, e_busy, e_done});
            end
            if (k >= 7) begin
                n_checks++;
                if (p !== exp_p) begin
                    n_fail++;
                    $display("FAIL %s_p: cycle %0d a=%0d b=%0d p=%h required %h",
                             name, k, a, b, p, exp_p);
                end
            end
            if (k == 1)      ia = a;
            else if (k == 2) ia = b;
            else             ia = 4'($urandom);
            start = (k == 8) ? 1'b0 : 1'($urandom);
        end
        cyc();
    endtask

    task automatic test_basic();
        run_op(4'd3, 4'd5, "basic");
    endtask

    task automatic test_max();
        run_op(4'd15, 4'd15, "max");
    endtask

    task automatic test_zero();
        run_op(4'd0, 4'd9, "zero_m");
        run_op(4'd9, 4'd0, "zero_q");
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            run_op(4'($urandom), 4'($urandom), "rand");
        end
    endtask

    task automatic test_mid_reset();
        start = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            if (k == 1)      ia = 4'd7;
            else if (k == 2) ia = 4'd6;
            start = 1'b0;
            rstn  = (k == 4) ? 1'b0 : 1'b1;
            if (k >= 5) begin
                n_checks++;
                if ({c1, busy, done} !== 3'b000 || p !== 8'h00) begin
                    n_fail++;
                    $display("FAIL midreset: cycle %0d {c1,busy,done}=%b p=%h required 000 / 00",
                             k, {c1, busy, done}, p);
                end
            end
        end
        rstn = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [3:0] ops [4];
        logic [7:0] exp_p;
        ops[0] = 4'd2; ops[1] = 4'd7; ops[2] = 4'd6; ops[3] = 4'd4;
        start = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            cyc();
            if (k == 1)       ia = ops[0];
            else if (k == 2)  ia = ops[1];
            else if (k == 9)  ia = ops[2];
            else if (k == 10) ia = ops[3];
            else              ia = 4'($urandom);
            n_checks++;
            if (done !== (k == 7 || k == 15)) begin
                n_fail++;
                $display("FAIL b2b_done: cycle %0d done=%b required %b", k, done, (k == 7 || k == 15));
            end
            n_checks++;
            if (c1 !== (k == 1 || k == 9)) begin
                n_fail++;
                $display("FAIL b2b_c1: cycle %0d c1=%b required %b", k, c1, (k == 1 || k == 9));
            end
            if (k == 7 || k == 15) begin
                exp_p = (k == 7) ? 8'(ops[0]) * 8'(ops[1]) : 8'(ops[2]) * 8'(ops[3]);
                n_checks++;
                if (p !== exp_p) begin
                    n_fail++;
                    $display("FAIL b2b_p: cycle %0d p=%h required %h", k, p, exp_p);
                end
            end
        end
        start = 1'b0;
        cyc();
        cyc();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rstn     = 1'b0;
        start    = 1'b0;
        ia       = 4'd0;
        cyc();
        cyc();
        test_reset();
        test_basic();
        test_max();
        test_zero();
        test_mid_reset();
        test_reset();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
